alu_seq_driver: RTL and testbench

ALU_SEQ_DRIVER -- requirements
Module: alu_seq_driver

---
 rtl/alu_drv_pkg.sv | 36 +++
 rtl/alu_sat_cnt.sv | 24 ++
 rtl/alu_seq_driver.sv | 167 ++++++++++++++++
 tb/tb_alu_seq_driver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_drv_pkg.sv
// Shared definitions for the ALU sequence driver.
// Contents: the FSM state type, the o_btn strobe bit indices, the ALU opcode
// constants and the width of the pass/fail transaction counters.
package alu_drv_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD_A  = 4'd1,
        ST_GAP_A   = 4'd2,
        ST_LOAD_B  = 4'd3,
        ST_GAP_B   = 4'd4,
        ST_LOAD_OP = 4'd5,
        ST_GAP_OP  = 4'd6,
        ST_WAIT    = 4'd7,
        ST_CHECK   = 4'd8
    } state_t;

    // Bit positions in o_btn
    localparam int unsigned BTN_A  = 0;
    localparam int unsigned BTN_B  = 1;
    localparam int unsigned BTN_OP = 2;

    // ALU opcodes
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    // Width of the pass/fail transaction counters
    localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/alu_sat_cnt.sv
// Saturating up-counter.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears the count
//   inc   - increment request for this cycle
//   count - current value; holds at all-ones instead of wrapping
module alu_sat_cnt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/alu_seq_driver.sv
// Drives one ALU transaction through the board-style top_alu interface:
// loads A, B and the opcode over the shared switch bus with one-hot button
// strobes, waits SETTLE_CYC cycles, captures the ALU result and compares it
// with the expected value, keeping saturating pass/fail counts.
// Ports:
//   clk, i_rst          - clock and synchronous active-high reset
//   i_start             - start request, honoured only when idle
//   i_data_a, i_data_b  - operands (latched on start)
//   i_op, i_expected    - opcode and expected result (latched on start)
//   i_alu_result        - result returned by the ALU
//   o_valid, o_btn      - ALU valid and load strobes (A, B, opcode)
//   o_sw_data           - value presented on the ALU switch bus
//   o_busy, o_done      - transaction in progress / one-cycle completion
//   o_result, o_pass    - captured result and comparison outcome
//   o_pass_cnt/o_fail_cnt - saturating transaction counters
module alu_seq_driver
    import alu_drv_pkg::*;
#(
    parameter int unsigned NB_DATA    = 8,
    parameter int unsigned NB_OP      = 6,
    parameter int unsigned SETTLE_CYC = 4
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    input  logic [NB_OP-1:0]   i_op,
    input  logic [NB_DATA-1:0] i_expected,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_valid,
    output logic [2:0]         o_btn,
    output logic [NB_DATA-1:0] o_sw_data,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_result,
    output logic               o_pass,
    output logic [CNT_W-1:0]   o_pass_cnt,
    output logic [CNT_W-1:0]   o_fail_cnt
);

    localparam int unsigned WAIT_W = $clog2(SETTLE_CYC + 1);

    state_t             state;
    state_t             next_state;
    logic [NB_DATA-1:0] a_q;
    logic [NB_DATA-1:0] b_q;
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] exp_q;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               accept;
    logic               capture;
    logic               pass_inc;
    logic               fail_inc;

    assign accept  = (state == ST_IDLE) && i_start;
    // Last WAIT cycle: the counter has run down to zero
    assign capture = (state == ST_WAIT) && (wait_cnt == '0);

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        o_btn      = '0;
        o_sw_data  = '0;
        o_done     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_start) next_state = ST_LOAD_A;
            end
            ST_LOAD_A: begin
                o_btn[BTN_A] = 1'b1;
                o_sw_data    = a_q;
                next_state   = ST_GAP_A;
            end
            ST_GAP_A: begin
                o_sw_data  = a_q;
                next_state = ST_LOAD_B;
            end
            ST_LOAD_B: begin
                o_btn[BTN_B] = 1'b1;
                o_sw_data    = b_q;
                next_state   = ST_GAP_B;
            end
            ST_GAP_B: begin
                o_sw_data  = b_q;
                next_state = ST_LOAD_OP;
            end
            ST_LOAD_OP: begin
                o_btn[BTN_OP] = 1'b1;
                o_sw_data     = NB_DATA'(op_q);
                next_state    = ST_GAP_OP;
            end
            ST_GAP_OP: begin
                o_sw_data  = NB_DATA'(op_q);
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                o_sw_data = NB_DATA'(op_q);
                if (wait_cnt == '0) next_state = ST_CHECK;
            end
            ST_CHECK: begin
                o_done     = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign o_busy  = (state != ST_IDLE);
    assign o_valid = (state != ST_IDLE);

    // Transaction registers: operands on accept, wait counter loaded in
    // GAP_OP so WAIT sees SETTLE_CYC-1 .. 0, result captured on the last
    // WAIT edge.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            exp_q    <= '0;
            wait_cnt <= '0;
            o_result <= '0;
            o_pass   <= 1'b0;
        end else begin
            if (accept) begin
                a_q   <= i_data_a;
                b_q   <= i_data_b;
                op_q  <= i_op;
                exp_q <= i_expected;
            end
            if (state == ST_GAP_OP) begin
                wait_cnt <= WAIT_W'(SETTLE_CYC - 1);
            end else if ((state == ST_WAIT) && (wait_cnt != '0)) begin
                wait_cnt <= wait_cnt - WAIT_W'(1);
            end
            if (capture) begin
                o_result <= i_alu_result;
                o_pass   <= (i_alu_result == exp_q);
            end
        end
    end

    assign pass_inc = (state == ST_CHECK) && o_pass;
    assign fail_inc = (state == ST_CHECK) && !o_pass;

    alu_sat_cnt #(.WIDTH(CNT_W)) u_pass_cnt (
        .clk   (clk),
        .rst   (i_rst),
        .inc   (pass_inc),
        .count (o_pass_cnt)
    );

    alu_sat_cnt #(.WIDTH(CNT_W)) u_fail_cnt (
        .clk   (clk),
        .rst   (i_rst),
        .inc   (fail_inc),
        .count (o_fail_cnt)
    );

endmodule

// File: tb/tb_alu_seq_driver.sv
// Directed testbench for alu_seq_driver at the default parameters.
// Cycle k below means the k-th clock period after the edge that samples
// i_start; outputs are sampled on the falling edge.
module tb_alu_seq_driver;
    import alu_drv_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [5:0] op;
    logic [7:0] expected;
    logic [7:0] alu_result;
    logic       valid;
    logic [2:0] btn;
    logic [7:0] sw_data;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       pass;
    logic [7:0] pass_cnt;
    logic [7:0] fail_cnt;

    int checks   = 0;
    int failures = 0;

    alu_seq_driver #(.NB_DATA(8), .NB_OP(6), .SETTLE_CYC(4)) dut (
        .clk          (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_data_a     (data_a),
        .i_data_b     (data_b),
        .i_op         (op),
        .i_expected   (expected),
        .i_alu_result (alu_result),
        .o_valid      (valid),
        .o_btn        (btn),
        .o_sw_data    (sw_data),
        .o_busy       (busy),
        .o_done       (done),
        .o_result     (result),
        .o_pass       (pass),
        .o_pass_cnt   (pass_cnt),
        .o_fail_cnt   (fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; data_a = '0; data_b = '0; op = '0;
        expected = '0; alu_result = '0;
        repeat (3) @(negedge clk);
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (btn !== 3'b000) begin failures++; $display("FAIL reset_btn: got %b expected 000", btn); end
        checks++; if (sw_data !== 8'd0) begin failures++; $display("FAIL reset_sw: got %0d expected 0", sw_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== 8'd0) begin failures++; $display("FAIL reset_result: got %0d expected 0", result); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL reset_pass: got %b expected 0", pass); end
        checks++; if (pass_cnt !== 8'd0) begin failures++; $display("FAIL reset_pass_cnt: got %0d expected 0", pass_cnt); end
        checks++; if (fail_cnt !== 8'd0) begin failures++; $display("FAIL reset_fail_cnt: got %0d expected 0", fail_cnt); end
        rst = 1'b0;
    endtask

    // ADD 15+10: strobe/bus timing per cycle, latching, capture and hold.
    task automatic test_add();
        logic [2:0] exp_btn [1:12];
        logic [7:0] exp_sw  [1:12];
        logic       exp_act [1:12];
        exp_btn = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000,
                    3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        exp_sw  = '{8'd15, 8'd15, 8'd10, 8'd10, 8'h20, 8'h20,
                    8'h20, 8'h20, 8'h20, 8'h20, 8'd0, 8'd0};
        exp_act = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        data_a = 8'd15; data_b = 8'd10; op = OP_ADD; expected = 8'd25;
        alu_result = 8'd0; start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 1) begin
                data_a = 8'd99; data_b = 8'd77; op = OP_SUB; expected = 8'd0;
            end
            // Correct result present only during the last WAIT cycle
            if (k == 10) alu_result = 8'd25;
            if (k == 11) alu_result = 8'd99;
            checks++; if (btn !== exp_btn[k]) begin failures++; $display("FAIL add_btn c%0d: got %b expected %b", k, btn, exp_btn[k]); end
            checks++; if (sw_data !== exp_sw[k]) begin failures++; $display("FAIL add_sw c%0d: got %0d expected %0d", k, sw_data, exp_sw[k]); end
            checks++; if (valid !== exp_act[k]) begin failures++; $display("FAIL add_valid c%0d: got %b expected %b", k, valid, exp_act[k]); end
            checks++; if (busy !== exp_act[k]) begin failures++; $display("FAIL add_busy c%0d: got %b expected %b", k, busy, exp_act[k]); end
            checks++; if (done !== (k == 11)) begin failures++; $display("FAIL add_done c%0d: got %b expected %b", k, done, (k == 11)); end
            if (k >= 11) begin
                checks++; if (result !== 8'd25) begin failures++; $display("FAIL add_result c%0d: got %0d expected 25", k, result); end
                checks++; if (pass !== 1'b1) begin failures++; $display("FAIL add_pass c%0d: got %b expected 1", k, pass); end
            end
        end
        checks++; if (pass_cnt !== 8'd1) begin failures++; $display("FAIL add_pass_cnt: got %0d expected 1", pass_cnt); end
        checks++; if (fail_cnt !== 8'd0) begin failures++; $display("FAIL add_fail_cnt: got %0d expected 0", fail_cnt); end
    endtask

    // SUB with a wrong expected value (6 vs ALU 5)
    task automatic test_sub_mismatch();
        int done_cyc = 0;
        data_a = 8'd15; data_b = 8'd10; op = OP_SUB; expected = 8'd6;
        alu_result = 8'd5; start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin done_cyc = k; break; end
        end
        checks++; if (done_cyc != 11) begin failures++; $display("FAIL sub_done_cycle: got %0d expected 11", done_cyc); end
        checks++; if (result !== 8'd5) begin failures++; $display("FAIL sub_result: got %0d expected 5", result); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL sub_pass: got %b expected 0", pass); end
        @(negedge clk);
        checks++; if (fail_cnt !== 8'd1) begin failures++; $display("FAIL sub_fail_cnt: got %0d expected 1", fail_cnt); end
        checks++; if (pass_cnt !== 8'd1) begin failures++; $display("FAIL sub_pass_cnt: got %0d expected 1", pass_cnt); end
    endtask

    // Start pulses in GAP_B (cycle 4) and CHECK (cycle 11) are ignored
    task automatic test_start_busy();
        int done_n = 0;
        int done_cyc = 0;
        int busy_late = 0;
        data_a = 8'd15; data_b = 8'd10; op = OP_ADD; expected = 8'd25;
        alu_result = 8'd25; start = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            start = (k == 4) || (k == 11);
            if (done) begin done_n++; done_cyc = k; end
            if ((k >= 12) && busy) busy_late++;
        end
        start = 1'b0;
        checks++; if (done_n != 1) begin failures++; $display("FAIL busy_done_count: got %0d expected 1", done_n); end
        checks++; if (done_cyc != 11) begin failures++; $display("FAIL busy_done_cycle: got %0d expected 11", done_cyc); end
        checks++; if (busy_late != 0) begin failures++; $display("FAIL busy_after_done: got %0d busy cycles expected 0", busy_late); end
        checks++; if (pass_cnt !== 8'd2) begin failures++; $display("FAIL busy_pass_cnt: got %0d expected 2", pass_cnt); end
    endtask

    // i_start held high: next transaction accepted from the IDLE after CHECK
    task automatic test_back_to_back();
        int done_cyc = 0;
        int done2 = 0;
        data_a = 8'd7; data_b = 8'd3; op = OP_ADD; expected = 8'd10;
        alu_result = 8'd10; start = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (k == 12) data_a = 8'd40;
            if (done) done_cyc = k;
        end
        start = 1'b0;
        checks++; if (done_cyc != 11) begin failures++; $display("FAIL b2b_first_done: got %0d expected 11", done_cyc); end
        checks++; if (btn !== 3'b001) begin failures++; $display("FAIL b2b_btn_c13: got %b expected 001", btn); end
        checks++; if (sw_data !== 8'd40) begin failures++; $display("FAIL b2b_sw_c13: got %0d expected 40", sw_data); end
        for (int k = 14; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin done2 = k; break; end
        end
        checks++; if (done2 != 23) begin failures++; $display("FAIL b2b_second_done: got %0d expected 23", done2); end
        @(negedge clk);
        checks++; if (pass_cnt !== 8'd4) begin failures++; $display("FAIL b2b_pass_cnt: got %0d expected 4", pass_cnt); end
    endtask

    // Reset asserted during LOAD_B (cycle 3)
    task automatic test_reset_mid();
        int done_n = 0;
        data_a = 8'd15; data_b = 8'd10; op = OP_ADD; expected = 8'd25;
        alu_result = 8'd25; start = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if (btn !== 3'b010) begin failures++; $display("FAIL rmid_in_load_b: got %b expected 010", btn); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rmid_valid: got %b expected 0", valid); end
        checks++; if (btn !== 3'b000) begin failures++; $display("FAIL rmid_btn: got %b expected 000", btn); end
        checks++; if (sw_data !== 8'd0) begin failures++; $display("FAIL rmid_sw: got %0d expected 0", sw_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        checks++; if (result !== 8'd0) begin failures++; $display("FAIL rmid_result: got %0d expected 0", result); end
        checks++; if (pass !== 1'b0) begin failures++; $display("FAIL rmid_pass: got %b expected 0", pass); end
        checks++; if (pass_cnt !== 8'd0) begin failures++; $display("FAIL rmid_pass_cnt: got %0d expected 0", pass_cnt); end
        checks++; if (fail_cnt !== 8'd0) begin failures++; $display("FAIL rmid_fail_cnt: got %0d expected 0", fail_cnt); end
        for (int k = 0; k < 16; k++) begin
            if (done) done_n++;
            @(negedge clk);
        end
        checks++; if (done_n != 0) begin failures++; $display("FAIL rmid_no_done: got %0d pulses expected 0", done_n); end
    endtask

    // One bounded transaction; leaves the bench in the IDLE cycle after CHECK
    task automatic run_txn(input logic [7:0] a, input logic [7:0] b,
                           input logic [5:0] o, input logic [7:0] e,
                           input logic [7:0] r);
        logic seen = 1'b0;
        data_a = a; data_b = b; op = o; expected = e; alu_result = r;
        start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin seen = 1'b1; break; end
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL txn_timeout: got no done expected done within 40 cycles"); end
        @(negedge clk);
    endtask

    task automatic test_saturation();
        for (int n = 1; n <= 260; n++) begin
            run_txn(8'd1, 8'd2, OP_ADD, 8'd3, 8'd3);
            if (n == 255) begin
                checks++; if (pass_cnt !== 8'd255) begin failures++; $display("FAIL sat_at_255: got %0d expected 255", pass_cnt); end
            end
        end
        checks++; if (pass_cnt !== 8'd255) begin failures++; $display("FAIL sat_pass_cnt: got %0d expected 255", pass_cnt); end
        checks++; if (fail_cnt !== 8'd0) begin failures++; $display("FAIL sat_fail_cnt: got %0d expected 0", fail_cnt); end
        run_txn(8'd1, 8'd2, OP_ADD, 8'd3, 8'd4);
        checks++; if (fail_cnt !== 8'd1) begin failures++; $display("FAIL sat_then_fail: got %0d expected 1", fail_cnt); end
        checks++; if (pass_cnt !== 8'd255) begin failures++; $display("FAIL sat_hold: got %0d expected 255", pass_cnt); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_mismatch();
        test_start_busy();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
